// File: rtl/nibble_serial_adder_seq_if.sv
// Bus bundle for nibble_serial_adder_seq.
// Groups three signal sets:
//   - input beat stream:   in_valid/in_ready/in_a/in_b/in_cin/in_last
//   - external adder link: add_a/add_b/add_ci out, add_sum/add_co back
//   - result stream:       out_valid/out_ready/out_sum/out_co/out_nbeats/out_err
// The slave modport is the sequencer's view.
// The master modport is the environment's view (producer, adder and consumer).
interface nibble_serial_adder_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned SumW = 4 * NIBBLES;
    localparam int unsigned NbW  = $clog2(NIBBLES + 1);

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_a;
    logic [3:0]      in_b;
    logic            in_cin;
    logic            in_last;

    logic [3:0]      add_a;
    logic [3:0]      add_b;
    logic            add_ci;
    logic [3:0]      add_sum;
    logic            add_co;

    logic            out_valid;
    logic            out_ready;
    logic [SumW-1:0] out_sum;
    logic            out_co;
    logic [NbW-1:0]  out_nbeats;
    logic            out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_last,
        output in_ready,
        output add_a, add_b, add_ci,
        input  add_sum, add_co,
        output out_valid, out_sum, out_co, out_nbeats, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_last,
        input  in_ready,
        input  add_a, add_b, add_ci,
        output add_sum, add_co,
        input  out_valid, out_sum, out_co, out_nbeats, out_err,
        output out_ready
    );
endinterface

// File: rtl/nibble_serial_adder_seq.sv
// Nibble-serial adder sequencer.
// Feeds one nibble pair per beat through an external 4-bit ripple adder.
// Carries the adder's carry-out into the next beat.
// Assembles the per-beat sums into a 4*NIBBLES-bit result word.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-high reset
//   bus - nibble_serial_adder_seq_if.slave, carrying:
//         - input beat handshake
//         - adder drive and return
//         - result handshake
//
// States:
//   StIdle  - waiting for a first beat
//   StAccum - mid-packet
//   StHold  - result presented until out_ready
module nibble_serial_adder_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input logic                      clk,
    input logic                      rst,
    nibble_serial_adder_seq_if.slave bus
);
    localparam int unsigned SumW = 4 * NIBBLES;
    localparam int unsigned NbW  = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e          state_q;
    logic [NbW-1:0]  idx_q;
    logic            carry_q;
    logic            out_valid_q;
    logic [SumW-1:0] out_sum_q;
    logic            out_co_q;
    logic [NbW-1:0]  out_nbeats_q;
    logic            out_err_q;

    logic accept;
    logic close_accum;

    // Adder is driven every cycle.
    // Its result only matters on an accepted beat.
    assign bus.add_a  = bus.in_a;
    assign bus.add_b  = bus.in_b;
    assign bus.add_ci = (state_q == StIdle) ? bus.in_cin : carry_q;

    assign bus.in_ready = !rst && (state_q != StHold);
    assign accept       = bus.in_valid && bus.in_ready;

    // Mid-packet closes on in_last or when the last nibble slot is filled.
    assign close_accum = bus.in_last || (idx_q == NbW'(NIBBLES - 1));

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_co     = out_co_q;
    assign bus.out_nbeats = out_nbeats_q;
    assign bus.out_err    = out_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_co_q     <= 1'b0;
            out_nbeats_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        // Clearing the word makes unwritten upper nibbles read 0.
                        out_sum_q <= SumW'(bus.add_sum);
                        carry_q   <= bus.add_co;
                        idx_q     <= NbW'(1);
                        if (bus.in_last) begin
                            out_co_q     <= bus.add_co;
                            out_nbeats_q <= NbW'(1);
                            out_err_q    <= 1'b0;
                            out_valid_q  <= 1'b1;
                            state_q      <= StHold;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        for (int k = 0; k < int'(NIBBLES); k++) begin
                            if (idx_q == NbW'(k)) begin
                                out_sum_q[4*k +: 4] <= bus.add_sum;
                            end
                        end
                        carry_q <= bus.add_co;
                        idx_q   <= idx_q + NbW'(1);
                        if (close_accum) begin
                            out_co_q     <= bus.add_co;
                            out_nbeats_q <= idx_q + NbW'(1);
                            out_err_q    <= !bus.in_last;
                            out_valid_q  <= 1'b1;
                            state_q      <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
